// File: rtl/exe_pkg.sv
// Shared encodings for the EX stage: ALU ops, multiply/divide ops, MDU states, forward selects.
package exe_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  localparam logic [1:0] FWD_RD1     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_FIXUP = 2'd2
  } mdState_e;

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, sign fixup, HI/LO registers.
module md_unit
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  mdState_e          state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] q, bReg, aSave;
  logic              isDiv, negQ, negR, divZero;

  logic              opSigned, aNeg, bNeg;
  logic [DATA_W-1:0] aMag, bMag;
  logic [DATA_W:0]   mulSum, divShift;
  logic [DATA_W+1:0] divDiff;
  logic [2*DATA_W-1:0] prod, prodFix;
  logic [DATA_W-1:0] quot, rem;

  assign opSigned = (op == MD_MULT) || (op == MD_DIV);
  assign aNeg     = opSigned & a[DATA_W-1];
  assign bNeg     = opSigned & b[DATA_W-1];
  assign aMag     = aNeg ? -a : a;
  assign bMag     = bNeg ? -b : b;

  // multiply: {acc,q} shifts right; divide: {acc,q} shifts left with restoring subtract
  assign mulSum   = acc + {1'b0, (q[0] ? bReg : {DATA_W{1'b0}})};
  assign divShift = {acc[DATA_W-1:0], q[DATA_W-1]};
  assign divDiff  = {1'b0, divShift} - {2'b00, bReg};

  assign prod     = {acc[DATA_W-1:0], q};
  assign prodFix  = negQ ? -prod : prod;
  assign quot     = negQ ? -q : q;
  assign rem      = negR ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];

  assign busy     = (state != MD_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      acc     <= '0;
      q       <= '0;
      bReg    <= '0;
      aSave   <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          acc     <= '0;
          q       <= aMag;
          bReg    <= bMag;
          aSave   <= a;
          isDiv   <= (op == MD_DIV) || (op == MD_DIVU);
          negQ    <= aNeg ^ bNeg;
          negR    <= aNeg;
          divZero <= (b == '0);
          cnt     <= '0;
          state   <= MD_RUN;
        end
        MD_RUN: begin
          if (isDiv) begin
            if (!divDiff[DATA_W+1]) begin
              acc <= divDiff[DATA_W:0];
              q   <= {q[DATA_W-2:0], 1'b1};
            end else begin
              acc <= divShift;
              q   <= {q[DATA_W-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, mulSum[DATA_W:1]};
            q   <= {mulSum[0], q[DATA_W-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1)) state <= MD_FIXUP;
        end
        MD_FIXUP: begin
          if (!isDiv) begin
            hi <= prodFix[2*DATA_W-1:DATA_W];
            lo <= prodFix[DATA_W-1:0];
          end else if (divZero) begin
            hi <= aSave;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quot;
          end
          cnt   <= '0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_md.sv
// MIPS EX stage: forwarding muxes, single-cycle ALU, dest-reg select, and an iterative MDU with stall.
module execute_stage_md
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_e,
  input  logic              alu_src_e,
  input  logic              reg_dst_e,
  input  logic [1:0]        fwd_a_e,
  input  logic [1:0]        fwd_b_e,
  input  logic [3:0]        alu_ctrl_e,
  input  logic [2:0]        md_op_e,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] sign_imm_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [DATA_W-1:0] result_w,
  input  logic [DATA_W-1:0] alu_out_m,
  output logic [DATA_W-1:0] alu_out_e,
  output logic [DATA_W-1:0] write_data_e,
  output logic [REG_AW-1:0] write_reg_e,
  output logic              ovf_e,
  output logic              zero_e,
  output logic              stall_e,
  output logic              md_busy
);

  localparam int SHW = $clog2(DATA_W);

  logic [DATA_W-1:0] srcA, fwdB, srcB, aluRes, sum, diff, hi, lo;
  logic [SHW-1:0]    shamt;
  logic              isMd, isMulDiv, mdStart;

  always_comb begin
    case (fwd_a_e)
      FWD_RESULTW: srcA = result_w;
      FWD_ALUOUTM: srcA = alu_out_m;
      default:     srcA = rd1_e;
    endcase
    case (fwd_b_e)
      FWD_RESULTW: fwdB = result_w;
      FWD_ALUOUTM: fwdB = alu_out_m;
      default:     fwdB = rd2_e;
    endcase
  end

  assign srcB         = alu_src_e ? sign_imm_e : fwdB;
  assign write_data_e = fwdB;
  assign write_reg_e  = reg_dst_e ? rd_e : rt_e;
  assign shamt        = srcB[SHW-1:0];
  assign sum          = srcA + srcB;
  assign diff         = srcA - srcB;

  always_comb begin
    aluRes = '0;
    ovf_e  = 1'b0;
    case (alu_ctrl_e)
      ALU_AND:  aluRes = srcA & srcB;
      ALU_OR:   aluRes = srcA | srcB;
      ALU_XOR:  aluRes = srcA ^ srcB;
      ALU_NOR:  aluRes = ~(srcA | srcB);
      ALU_ADD: begin
        aluRes = sum;
        ovf_e  = (srcA[DATA_W-1] == srcB[DATA_W-1]) && (sum[DATA_W-1] != srcA[DATA_W-1]);
      end
      ALU_SUB: begin
        aluRes = diff;
        ovf_e  = (srcA[DATA_W-1] != srcB[DATA_W-1]) && (diff[DATA_W-1] != srcA[DATA_W-1]);
      end
      ALU_SLT:  aluRes = {{(DATA_W-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SLTU: aluRes = {{(DATA_W-1){1'b0}}, (srcA < srcB)};
      ALU_SLL:  aluRes = srcA << shamt;
      ALU_SRL:  aluRes = srcA >> shamt;
      ALU_SRA:  aluRes = $unsigned($signed(srcA) >>> shamt);
      default:  aluRes = '0;
    endcase
  end

  // MFHI/MFLO only complete while the MDU is idle, since stall_e holds them otherwise
  always_comb begin
    case (md_op_e)
      MD_MFHI: alu_out_e = hi;
      MD_MFLO: alu_out_e = lo;
      default: alu_out_e = aluRes;
    endcase
  end

  assign zero_e   = (alu_out_e == '0);
  assign isMd     = (md_op_e != MD_NONE) && (md_op_e <= MD_MFLO);
  assign isMulDiv = (md_op_e >= MD_MULT) && (md_op_e <= MD_DIVU);
  assign stall_e  = valid_e & md_busy & isMd;
  assign mdStart  = valid_e & ~stall_e & isMulDiv & ~md_busy;

  md_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) uMd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdStart),
    .op    (md_op_e),
    .a     (srcA),
    .b     (fwdB),
    .hi    (hi),
    .lo    (lo),
    .busy  (md_busy)
  );

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU vector table plus MDU timing/result sequences.
module tb_execute_stage_md;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_e, alu_src_e, reg_dst_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  md_op_e;
  logic [31:0] rd1_e, rd2_e, sign_imm_e, result_w, alu_out_m;
  logic [4:0]  rt_e, rd_e;
  logic [31:0] alu_out_e, write_data_e;
  logic [4:0]  write_reg_e;
  logic        ovf_e, zero_e, stall_e, md_busy;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  execute_stage_md #(.DATA_W(32), .REG_AW(5), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .alu_ctrl_e(alu_ctrl_e), .md_op_e(md_op_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e), .rt_e(rt_e), .rd_e(rd_e),
    .result_w(result_w), .alu_out_m(alu_out_m), .alu_out_e(alu_out_e),
    .write_data_e(write_data_e), .write_reg_e(write_reg_e), .ovf_e(ovf_e), .zero_e(zero_e),
    .stall_e(stall_e), .md_busy(md_busy)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic        src, dst;
    logic [3:0]  ctrl;
    logic [31:0] r1, r2, imm, rw, am;
    logic [4:0]  rt, rd;
    logic [31:0] eOut, eWd;
    logic [4:0]  eWr;
    logic        eOvf, eZero;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b);
    valid_e = v; md_op_e = op; alu_ctrl_e = ctrl; rd1_e = a; rd2_e = b;
    fwd_a_e = 2'b00; fwd_b_e = 2'b00; alu_src_e = 1'b0;
  endtask

  // Holds current inputs and counts negedges with stall_e high; ends at the first unstalled negedge.
  task automatic countStall(output int n);
    n = 0;
    @(negedge clk);
    while (stall_e && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo, input string nm);
    int n;
    @(posedge clk); #1; drive(1'b1, op, ALU_ADD, a, b);
    @(posedge clk); #1; drive(1'b0, MD_NONE, ALU_ADD, 0, 0);
    n = 0;
    @(negedge clk);
    while (md_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy cycles"}, n, 33);
    @(posedge clk); #1; drive(1'b1, MD_MFLO, ALU_ADD, 0, 0);
    @(negedge clk); chk({nm, " LO"}, alu_out_e, expLo);
    @(posedge clk); #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    @(negedge clk); chk({nm, " HI"}, alu_out_e, expHi);
    @(posedge clk); #1; drive(1'b0, MD_NONE, ALU_ADD, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          fa fb src dst ctrl       r1            r2            imm           rw  am  rt  rd  eOut          eWd           eWr ovf zero
    vecs[0]  = '{2, 0, 0, 0, ALU_ADD,  32'd1,        32'd5,        32'd0,        32'd0, 32'd7, 5'd3, 5'd9,  32'd12,       32'd5,        5'd3,  0, 0};
    vecs[1]  = '{1, 0, 0, 0, ALU_ADD,  32'd1,        32'd5,        32'd0,        32'd3, 32'd7, 5'd3, 5'd9,  32'd8,        32'd5,        5'd3,  0, 0};
    vecs[2]  = '{0, 0, 0, 1, ALU_ADD,  32'h7FFFFFFF, 32'd1,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'h80000000, 32'd1,        5'd9,  1, 0};
    vecs[3]  = '{0, 0, 0, 0, ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'd1,        32'd1,        5'd3,  0, 0};
    vecs[4]  = '{0, 0, 0, 0, ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'd0,        32'd1,        5'd3,  0, 1};
    vecs[5]  = '{0, 0, 1, 0, ALU_SRA,  32'h80000000, 32'd9,        32'd4,        32'd0, 32'd0, 5'd3, 5'd9,  32'hF8000000, 32'd9,        5'd3,  0, 0};
    vecs[6]  = '{0, 0, 0, 1, ALU_SUB,  32'd5,        32'd5,        32'd0,        32'd0, 32'd0, 5'd3, 5'd17, 32'd0,        32'd5,        5'd17, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, ALU_SUB,  32'h80000000, 32'd1,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'h7FFFFFFF, 32'd1,        5'd3,  1, 0};
    vecs[8]  = '{0, 0, 0, 0, ALU_NOR,  32'd0,        32'd0,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'hFFFFFFFF, 32'd0,        5'd3,  0, 0};
    vecs[9]  = '{0, 0, 1, 0, ALU_SLL,  32'd1,        32'd0,        32'd31,       32'd0, 32'd0, 5'd3, 5'd9,  32'h80000000, 32'd0,        5'd3,  0, 0};
    vecs[10] = '{0, 0, 0, 0, ALU_SRL,  32'h80000000, 32'd31,       32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'd1,        32'd31,       5'd3,  0, 0};
    vecs[11] = '{0, 2, 0, 0, ALU_XOR,  32'd5,        32'd0,        32'd0,        32'd0, 32'd7, 5'd3, 5'd9,  32'd2,        32'd7,        5'd3,  0, 0};
    vecs[12] = '{3, 0, 0, 0, ALU_AND,  32'hF0,       32'h3C,       32'd0,        32'd3, 32'd7, 5'd3, 5'd9,  32'h30,       32'h3C,       5'd3,  0, 0};
    vecs[13] = '{0, 0, 0, 0, 4'hF,     32'd5,        32'd3,        32'd0,        32'd0, 32'd0, 5'd3, 5'd9,  32'd0,        32'd3,        5'd3,  0, 1};
    vecs[14] = '{0, 1, 0, 0, ALU_ADD,  32'hFFFFFFFF, 32'd9,        32'd0,        32'd1, 32'd0, 5'd3, 5'd9,  32'd0,        32'd1,        5'd3,  0, 1};
    vecs[15] = '{0, 0, 1, 0, ALU_ADD,  32'd10,       32'd6,        32'hFFFFFFFE, 32'd0, 32'd0, 5'd3, 5'd9,  32'd8,        32'd6,        5'd3,  0, 0};

    drive(1'b0, MD_NONE, ALU_ADD, 0, 0);
    reg_dst_e = 0; sign_imm_e = 0; rt_e = 0; rd_e = 0; result_w = 0; alu_out_m = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    @(negedge clk);
    chk("reset busy", md_busy, 0);
    chk("reset stall", stall_e, 0);
    chk("reset HI", alu_out_e, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      valid_e = 1; md_op_e = MD_NONE;
      fwd_a_e = vecs[i].fa; fwd_b_e = vecs[i].fb; alu_src_e = vecs[i].src; reg_dst_e = vecs[i].dst;
      alu_ctrl_e = vecs[i].ctrl; rd1_e = vecs[i].r1; rd2_e = vecs[i].r2; sign_imm_e = vecs[i].imm;
      result_w = vecs[i].rw; alu_out_m = vecs[i].am; rt_e = vecs[i].rt; rd_e = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d out", i), alu_out_e, vecs[i].eOut);
      chk($sformatf("vec%0d wdata", i), write_data_e, vecs[i].eWd);
      chk($sformatf("vec%0d wreg", i), {27'd0, write_reg_e}, {27'd0, vecs[i].eWr});
      chk($sformatf("vec%0d ovf", i), {31'd0, ovf_e}, {31'd0, vecs[i].eOvf});
      chk($sformatf("vec%0d zero", i), {31'd0, zero_e}, {31'd0, vecs[i].eZero});
      chk($sformatf("vec%0d stall", i), {31'd0, stall_e}, 32'd0);
    end
    @(posedge clk); #1; drive(1'b0, MD_NONE, ALU_ADD, 0, 0);
    sign_imm_e = 0; result_w = 0; alu_out_m = 0; reg_dst_e = 0;

    // MULT followed directly by a dependent MFLO
    @(posedge clk); #1; drive(1'b1, MD_MULT, ALU_ADD, 32'hFFFFFFFD, 32'd5);
    @(negedge clk); chk("mult issue stall", {31'd0, stall_e}, 0);
    @(posedge clk); #1; drive(1'b1, MD_MFLO, ALU_ADD, 0, 0);
    countStall(n);
    chk("mflo stall cycles", n, 33);
    chk("mult LO", alu_out_e, 32'hFFFFFFF1);
    @(posedge clk); #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    @(negedge clk); chk("mult HI", alu_out_e, 32'hFFFFFFFF);
    @(posedge clk); #1; drive(1'b0, MD_NONE, ALU_ADD, 0, 0);

    runMd(MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    runMd(MD_DIVU, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, "divu 7/0");
    runMd(MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div min/-1");
    runMd(MD_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       "divu 100/7");
    runMd(MD_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div 7/-2");

    // independent ALU op flows while MDU is busy
    @(posedge clk); #1; drive(1'b1, MD_MULTU, ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1; drive(1'b1, MD_NONE, ALU_ADD, 32'd2, 32'd3);
    @(negedge clk);
    chk("add during run stall", {31'd0, stall_e}, 0);
    chk("add during run busy", {31'd0, md_busy}, 1);
    chk("add during run out", alu_out_e, 32'd5);
    @(posedge clk); #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    countStall(n);
    chk("mfhi stall cycles", n, 32);
    chk("multu HI", alu_out_e, 32'hFFFFFFFE);
    @(posedge clk); #1; drive(1'b1, MD_MFLO, ALU_ADD, 0, 0);
    @(negedge clk); chk("multu LO", alu_out_e, 32'd1);

    // back-to-back MULTs: the second waits for IDLE then runs
    @(posedge clk); #1; drive(1'b1, MD_MULT, ALU_ADD, 32'd2, 32'd3);
    @(posedge clk); #1; drive(1'b1, MD_MULT, ALU_ADD, 32'd4, 32'd5);
    countStall(n);
    chk("mult2 stall cycles", n, 33);
    @(posedge clk); #1; drive(1'b1, MD_MFLO, ALU_ADD, 0, 0);
    countStall(n);
    chk("mult2 mflo stall", n, 33);
    chk("mult2 LO", alu_out_e, 32'd20);
    @(posedge clk); #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    @(negedge clk); chk("mult2 HI", alu_out_e, 32'd0);

    // asynchronous reset in the middle of RUN
    @(posedge clk); #1; drive(1'b1, MD_MULT, ALU_ADD, 32'd3, 32'd4);
    @(posedge clk); #1; drive(1'b1, MD_MFLO, ALU_ADD, 0, 0);
    repeat (9) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("mid-run reset busy", {31'd0, md_busy}, 0);
    chk("mid-run reset stall", {31'd0, stall_e}, 0);
    chk("mid-run reset LO", alu_out_e, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; drive(1'b1, MD_MFHI, ALU_ADD, 0, 0);
    @(negedge clk); chk("after reset HI", alu_out_e, 32'd0);
    @(posedge clk); #1; drive(1'b0, MD_NONE, ALU_ADD, 0, 0);
    runMd(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
